// File: rtl/data_mem_stage_pkg.sv
// Shared types for the data-memory stage: datapath word, register
// address, store-data source encoding and the load-result slot layout.
package data_mem_stage_pkg;

    localparam int WIDTH = 16;

    typedef logic [WIDTH-1:0] block;
    typedef logic [3:0]       reg_addr_t;

    // Store-data source; the reserved code behaves like SEL_VAL2.
    typedef enum logic [1:0] {
        SEL_VAL2   = 2'd0,
        SEL_RESULT = 2'd1,
        SEL_MEMVAL = 2'd2,
        SEL_RSVD   = 2'd3
    } st_fwd_e;

    // One load-result slot; an empty slot is all zeros.
    typedef struct packed {
        logic      wen;
        reg_addr_t rd;
        block      data;
    } ld_slot_t;

endpackage

// File: rtl/dmem_rd_pipe.sv
// Load-result shift register. Stage 0 captures the memory sample at the
// accept edge; stage STAGES drives the writeback outputs, so a load shows
// up STAGES edges after it was accepted. flush wins over hold.
module dmem_rd_pipe
    import data_mem_stage_pkg::*;
#(
    parameter int STAGES = 1
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      hold,
    input  logic      flush,
    input  logic      in_vld,
    input  logic      in_wen,
    input  reg_addr_t in_rd,
    input  block      in_data,
    output logic      out_wen,
    output reg_addr_t out_rd,
    output block      out_data
);

    logic     [STAGES:0] vld_pipe;
    ld_slot_t [STAGES:0] slot_pipe;
    ld_slot_t            in_slot;

    // Non-load slots enter as zeros so the outputs read zero for them.
    always_comb begin
        in_slot = '0;
        if (in_vld) begin
            in_slot.wen  = in_wen;
            in_slot.rd   = in_rd;
            in_slot.data = in_data;
        end
    end

    // Shift one slot per edge; flush clears everything, hold freezes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_pipe  <= '0;
            slot_pipe <= '0;
        end else if (flush) begin
            vld_pipe  <= '0;
            slot_pipe <= '0;
        end else if (!hold) begin
            vld_pipe  <= {vld_pipe[STAGES-1:0], in_vld};
            slot_pipe <= {slot_pipe[STAGES-1:0], in_slot};
        end
    end

    assign out_wen  = vld_pipe[STAGES] & slot_pipe[STAGES].wen;
    assign out_rd   = slot_pipe[STAGES].rd;
    assign out_data = slot_pipe[STAGES].data;

endmodule

// File: rtl/data_mem_stage.sv
// Data-memory pipeline stage: register-file style memory with
// read-before-write, store-data forwarding and a pipelined load return.
// Optional macro DMEM_FAULT_EN: addresses >= DEPTH are out of range
// (loads return 0, stores dropped, sticky mem_fault); otherwise
// addresses wrap to $clog2(DEPTH) bits and mem_fault is tied low.
module data_mem_stage
    import data_mem_stage_pkg::*;
#(
    parameter int DEPTH    = 64,
    parameter int READ_LAT = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       do_halt,
    input  logic       do_branch,
    input  logic       req_valid,
    output logic       req_ready,
    input  block       val1,
    input  block       val2,
    input  block       val3,
    input  logic       is_mem_read,
    input  logic       is_mem_write,
    input  logic       is_reg_write,
    input  logic [1:0] st_fwd_sel,
    input  block       result,
    output logic       do_mem_reg_write,
    output block       mem_value,
    output logic [3:0] mem_reg_addr,
    output logic       mem_fault
);

    localparam int AW = $clog2(DEPTH);

    block mem [DEPTH];
    block ld_addr, st_addr, st_data, ld_data;
    logic accept, st_en, ld_vld;

    assign req_ready = !do_halt;
    assign accept    = req_valid && req_ready && !do_branch;
    assign ld_addr   = val1 + val2;
    assign st_addr   = val1 + val3;
    assign ld_vld    = accept && is_mem_read;

    // Store data source select; the reserved code falls back to val2.
    always_comb begin
        st_data = val2;
        case (st_fwd_e'(st_fwd_sel))
            SEL_RESULT: st_data = result;
            SEL_MEMVAL: st_data = mem_value;
            default:    st_data = val2;
        endcase
    end

`ifdef DMEM_FAULT_EN
    logic ld_oor, st_oor;
    assign ld_oor  = ld_addr >= block'(DEPTH);
    assign st_oor  = st_addr >= block'(DEPTH);
    assign ld_data = ld_oor ? '0 : mem[ld_addr[AW-1:0]];
    assign st_en   = accept && is_mem_write && !st_oor;

    // Sticky out-of-range flag, cleared only by reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            mem_fault <= 1'b0;
        else if (accept && ((is_mem_read && ld_oor) || (is_mem_write && st_oor)))
            mem_fault <= 1'b1;
    end
`else
    logic unused_addr_hi;
    assign unused_addr_hi = ^{ld_addr[WIDTH-1:AW], st_addr[WIDTH-1:AW]};
    assign ld_data   = mem[ld_addr[AW-1:0]];
    assign st_en     = accept && is_mem_write;
    assign mem_fault = 1'b0;
`endif

    // Memory array; the load sample above is taken before this write lands.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (st_en) begin
            mem[st_addr[AW-1:0]] <= st_data;
        end
    end

    dmem_rd_pipe #(.STAGES(READ_LAT)) u_rd_pipe (
        .clk      (clk),
        .rst      (rst),
        .hold     (do_halt),
        .flush    (do_branch),
        .in_vld   (ld_vld),
        .in_wen   (is_reg_write),
        .in_rd    (val3[3:0]),
        .in_data  (ld_data),
        .out_wen  (do_mem_reg_write),
        .out_rd   (mem_reg_addr),
        .out_data (mem_value)
    );

endmodule

// File: tb/tb_data_mem_stage.sv
// Directed bench for data_mem_stage (DEPTH=64, READ_LAT=2). Expected load
// results are queued when a load is driven and compared when due; every
// other cycle the writeback outputs must read zero.
module tb_data_mem_stage;
    import data_mem_stage_pkg::*;

    localparam int DEPTH = 64;
    localparam int RL    = 2;

    logic       clk = 1'b0;
    logic       rst, do_halt, do_branch, req_valid, req_ready;
    block       val1, val2, val3, result, mem_value;
    logic       is_mem_read, is_mem_write, is_reg_write;
    logic [1:0] st_fwd_sel;
    logic       do_mem_reg_write, mem_fault;
    logic [3:0] mem_reg_addr;

    typedef struct {
        int        due;
        block      data;
        reg_addr_t rd;
        logic      wen;
    } exp_t;

    exp_t q[$];
    int   cyc = 0, checks = 0, errors = 0;
    logic exp_fault = 1'b0;

    data_mem_stage #(.DEPTH(DEPTH), .READ_LAT(RL)) dut (
        .clk(clk), .rst(rst), .do_halt(do_halt), .do_branch(do_branch),
        .req_valid(req_valid), .req_ready(req_ready),
        .val1(val1), .val2(val2), .val3(val3),
        .is_mem_read(is_mem_read), .is_mem_write(is_mem_write),
        .is_reg_write(is_reg_write), .st_fwd_sel(st_fwd_sel), .result(result),
        .do_mem_reg_write(do_mem_reg_write), .mem_value(mem_value),
        .mem_reg_addr(mem_reg_addr), .mem_fault(mem_fault)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic mon();
        exp_t e;
        if (q.size() > 0 && q[0].due == cyc) begin
            e = q.pop_front();
            chk("ld_data", 32'(mem_value), 32'(e.data));
            chk("ld_rd", 32'(mem_reg_addr), 32'(e.rd));
            chk("ld_wen", 32'(do_mem_reg_write), 32'(e.wen));
        end else begin
            chk("idle_data", 32'(mem_value), 0);
            chk("idle_rd", 32'(mem_reg_addr), 0);
            chk("idle_wen", 32'(do_mem_reg_write), 0);
        end
        chk("fault", 32'(mem_fault), 32'(exp_fault));
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        #1;
        mon();
    endtask

    task automatic push(input int due, input int data, input int rd, input bit wen);
        exp_t e;
        e.due = due; e.data = block'(data); e.rd = reg_addr_t'(rd); e.wen = wen;
        q.push_back(e);
    endtask

    task automatic idle_in();
        req_valid = 0; is_mem_read = 0; is_mem_write = 0; is_reg_write = 0;
        val1 = '0; val2 = '0; val3 = '0; result = '0; st_fwd_sel = 2'd0;
    endtask

    task automatic load(input int base, input int off, input int rd, input int data, input bit rw = 1);
        val1 = block'(base); val2 = block'(off); val3 = block'(rd);
        is_mem_read = 1; is_mem_write = 0; is_reg_write = rw; st_fwd_sel = 2'd0;
        req_valid = 1;
        push(cyc + 1 + RL, data, rd, rw);
        tick();
        idle_in();
    endtask

    task automatic store(input int base, input int off, input int data,
                         input int sel = 0, input int res = 0);
        val1 = block'(base); val3 = block'(off); val2 = block'(data);
        result = block'(res); st_fwd_sel = 2'(sel);
        is_mem_read = 0; is_mem_write = 1; is_reg_write = 0; req_valid = 1;
        tick();
        idle_in();
    endtask

    task automatic drain();
        repeat (RL) tick();
    endtask

    int c;

    initial begin
        rst = 0; do_halt = 0; do_branch = 0;
        idle_in();
        #12;
        chk("rst_data", 32'(mem_value), 0);
        chk("rst_wen", 32'(do_mem_reg_write), 0);
        chk("rst_rd", 32'(mem_reg_addr), 0);
        chk("rst_fault", 32'(mem_fault), 0);
        chk("rst_ready", 32'(req_ready), 1);
        rst = 1;

        // Store on the first edge after reset, load it back next cycle.
        store(4, 3, 30000);
        load(5, 2, 7, 30000);
        load(20, 0, 3, 0);          // untouched word reads cleared value
        drain();

        // Load+store to the same word returns the pre-write data.
        store(10, 0, 5);
        val1 = 10; val2 = 0; val3 = 0; result = 9; st_fwd_sel = 2'd1;
        is_mem_read = 1; is_mem_write = 1; is_reg_write = 1; req_valid = 1;
        push(cyc + 1 + RL, 5, 0, 1);
        tick();
        idle_in();
        load(8, 2, 2, 9);
        load(10, 0, 5, 9, 0);       // no reg write: data still presented
        drain();

        // Store-data forwarding from result, mem_value and reserved code.
        store(30, 0, 3, 1, 77);
        store(40, 0, 10);
        load(40, 0, 1, 10);
        tick();
        tick();                     // mem_value == 10 during next cycle
        store(31, 0, 999, 2, 55);
        store(32, 0, 123, 3, 55);
        load(30, 0, 4, 77);
        load(31, 0, 5, 10);
        load(32, 0, 6, 123);
        drain();

        // Two loads then a branch (with halt and a store presented) kills all.
        val1 = 7; val2 = 0; val3 = 8; is_mem_read = 1; is_reg_write = 1; req_valid = 1;
        tick();
        val1 = 10; val3 = 9;
        tick();
        idle_in();
        val1 = 50; val3 = 0; val2 = 555; is_mem_write = 1; req_valid = 1;
        do_branch = 1; do_halt = 1;
        tick();
        do_branch = 0; do_halt = 0;
        idle_in();
        repeat (3) tick();
        load(50, 0, 1, 0);
        drain();

        // Halt with a load in flight; presented store must be ignored.
        c = cyc;
        val1 = 7; val2 = 0; val3 = 2; is_mem_read = 1; is_reg_write = 1; req_valid = 1;
        push(c + 1 + RL + 3, 30000, 2, 1);
        tick();
        idle_in();
        do_halt = 1;
        val1 = 51; val2 = 777; is_mem_write = 1; req_valid = 1;
        #1;
        chk("ready_halt", 32'(req_ready), 0);
        repeat (3) tick();
        do_halt = 0;
        idle_in();
        tick();
        tick();
        load(51, 0, 1, 0);
        drain();

        // Halt while a result is on the outputs: it stays there.
        c = cyc;
        load(7, 0, 3, 30000);
        tick();
        tick();
        do_halt = 1;
        push(c + 4, 30000, 3, 1);
        push(c + 5, 30000, 3, 1);
        tick();
        tick();
        do_halt = 0;
        tick();

`ifdef DMEM_FAULT_EN
        exp_fault = 1'b1;
        store(60, 10, 4321);        // address 70 is out of range
        load(3, 3, 1, 0);
        load(64, 6, 2, 0);
        drain();
`else
        store(60, 10, 4321);        // address 70 wraps to word 6
        load(3, 3, 1, 4321);
        load(64, 6, 2, 4321);
        drain();
`endif

        // Asynchronous reset mid-cycle clears outputs, flag and memory.
        load(7, 0, 3, 30000);
        tick();
        tick();
        #3;
        rst = 0;
        #1;
        chk("arst_data", 32'(mem_value), 0);
        chk("arst_wen", 32'(do_mem_reg_write), 0);
        chk("arst_fault", 32'(mem_fault), 0);
        exp_fault = 1'b0;
        rst = 1;
        load(10, 0, 1, 0);
        load(7, 0, 2, 0);
        drain();

        chk("sb_empty", 32'(q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
